// File: rtl/maze_pkg.sv
// Shared types, geometry and the neighbour-step helper for the DFS maze controller.
package maze_pkg;

    localparam int MAZE_DIM = 16;
    localparam int LOC_W    = 8;
    localparam int COORD_W  = 4;
    localparam int DEPTH_W  = 9;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [1:0]         dir_t;

    localparam dir_t DIR_R = 2'd0;  // y+1
    localparam dir_t DIR_D = 2'd1;  // x+1
    localparam dir_t DIR_L = 2'd2;  // y-1
    localparam dir_t DIR_U = 2'd3;  // x-1

    typedef enum logic [2:0] {
        S_IDLE,
        S_MARK,
        S_PROBE,
        S_RD,
        S_EV,
        S_BACK,
        S_DONE,
        S_FAIL
    } state_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   valid;
    } step_t;

    // One extra bit catches both 15+1 and 0-1, so no wrap-around is possible.
    function automatic step_t maze_step(input coord_t x, input coord_t y, input dir_t d);
        logic [COORD_W:0] nx;
        logic [COORD_W:0] ny;
        step_t            s;
        nx = {1'b0, x};
        ny = {1'b0, y};
        case (d)
            DIR_R:   ny = ny + (COORD_W+1)'(1);
            DIR_D:   nx = nx + (COORD_W+1)'(1);
            DIR_L:   ny = ny - (COORD_W+1)'(1);
            default: nx = nx - (COORD_W+1)'(1);
        endcase
        s.x     = nx[COORD_W-1:0];
        s.y     = ny[COORD_W-1:0];
        s.valid = !nx[COORD_W] && !ny[COORD_W];
        return s;
    endfunction

endpackage

// File: rtl/maze_solver_ctrl_if.sv
// Maze bit-memory bus: the controller is the master, the memory the slave.
interface maze_solver_ctrl_if;
    import maze_pkg::*;

    logic [LOC_W-1:0] mem_loc;
    logic             mem_rd;
    logic             mem_wr;
    logic             mem_din;
    logic             mem_dout;

    modport master (
        output mem_loc, mem_rd, mem_wr, mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_loc, mem_rd, mem_wr, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/maze_solver_ctrl_dir_stack.sv
// Path stack of 2-bit directions: synchronous push/pop, combinational top and indexed read.
module dir_stack
    import maze_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  dir_t               push_dir,
    output logic [DEPTH_W-1:0] depth,
    output dir_t               top_dir,
    input  logic [LOC_W-1:0]   rd_idx,
    output dir_t               rd_dir
);

    dir_t               stack_mem [1 << LOC_W];
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    always_comb begin
        // NOTE: default first so every path assigns depth_d; otherwise a latch is inferred.
        depth_d = depth_q;
        if (clear) begin
            depth_d = '0;
        end else if (push) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking for all state so every flop samples pre-edge values.
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    // NOTE: storage is deliberately not reset; depth alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[depth_q[LOC_W-1:0]] <= push_dir;
        end
    end

    assign depth   = depth_q;
    assign top_dir = stack_mem[depth_q[LOC_W-1:0] - LOC_W'(1)];
    assign rd_dir  = stack_mem[rd_idx];

endmodule

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze solver: marks visited cells, probes neighbours in R/D/L/U order, backtracks via the path stack.
module maze_solver_ctrl
    import maze_pkg::*;
#(
    parameter int START_X = 0,
    parameter int START_Y = 0,
    parameter int GOAL_X  = 15,
    parameter int GOAL_Y  = 15
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    maze_solver_ctrl_if.master  mem,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [DEPTH_W-1:0]  path_len,
    input  logic [LOC_W-1:0]    rd_idx,
    output dir_t                rd_dir
);

    localparam coord_t           START_XC  = coord_t'(START_X);
    localparam coord_t           START_YC  = coord_t'(START_Y);
    localparam coord_t           GOAL_XC   = coord_t'(GOAL_X);
    localparam coord_t           GOAL_YC   = coord_t'(GOAL_Y);
    localparam logic [LOC_W-1:0] START_LOC = {START_XC, START_YC};
    localparam logic [LOC_W-1:0] GOAL_LOC  = {GOAL_XC, GOAL_YC};

    state_t             state_q, state_d;
    coord_t             cur_x_q, cur_x_d;
    coord_t             cur_y_q, cur_y_d;
    logic [2:0]         dir_q, dir_d;
    logic [LOC_W-1:0]   loc_q, loc_d;
    logic               chk_q, chk_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [DEPTH_W-1:0] path_len_q, path_len_d;

    logic               stk_clear;
    logic               stk_push;
    logic               stk_pop;
    logic [DEPTH_W-1:0] depth;
    dir_t               top_dir;
    step_t              nbr;
    step_t              back;

    dir_stack u_stack (
        .clk      (clk),
        .rst      (rst),
        .clear    (stk_clear),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_dir (dir_q[1:0]),
        .depth    (depth),
        .top_dir  (top_dir),
        .rd_idx   (rd_idx),
        .rd_dir   (rd_dir)
    );

    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        dir_d      = dir_q;
        loc_d      = loc_q;
        chk_d      = chk_q;
        done_d     = done_q;
        fail_d     = fail_q;
        path_len_d = path_len_q;
        stk_clear  = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        nbr        = maze_step(cur_x_q, cur_y_q, dir_q[1:0]);
        // Undo the popped move by stepping in the opposite direction.
        back       = maze_step(cur_x_q, cur_y_q, top_dir ^ 2'b10);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    path_len_d = '0;
                    stk_clear  = 1'b1;
                    cur_x_d    = START_XC;
                    cur_y_d    = START_YC;
                    dir_d      = '0;
                    loc_d      = START_LOC;
                    chk_d      = 1'b1;
                    state_d    = S_RD;
                end
            end
            S_MARK: begin
                state_d = S_PROBE;
            end
            S_PROBE: begin
                if (dir_q[2]) begin
                    state_d = S_BACK;
                end else if (!nbr.valid) begin
                    dir_d = dir_q + 3'd1;
                end else begin
                    loc_d   = {nbr.x, nbr.y};
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_EV;
            end
            S_EV: begin
                if (chk_q) begin
                    chk_d = 1'b0;
                    if (mem.mem_dout) begin
                        state_d = S_FAIL;
                    end else if (START_LOC == GOAL_LOC) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MARK;
                    end
                end else if (mem.mem_dout) begin
                    dir_d   = dir_q + 3'd1;
                    state_d = S_PROBE;
                end else begin
                    // loc_q already holds the neighbour, so MARK writes the new cur.
                    stk_push = 1'b1;
                    cur_x_d  = loc_q[LOC_W-1:COORD_W];
                    cur_y_d  = loc_q[COORD_W-1:0];
                    dir_d    = '0;
                    state_d  = (loc_q == GOAL_LOC) ? S_DONE : S_MARK;
                end
            end
            S_BACK: begin
                if (depth == '0) begin
                    state_d = S_FAIL;
                end else begin
                    stk_pop = 1'b1;
                    cur_x_d = back.x;
                    cur_y_d = back.y;
                    dir_d   = {1'b0, top_dir} + 3'd1;
                    state_d = S_PROBE;
                end
            end
            S_DONE: begin
                done_d     = 1'b1;
                path_len_d = depth;
                state_d    = S_IDLE;
            end
            S_FAIL: begin
                fail_d     = 1'b1;
                path_len_d = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_x_q    <= START_XC;
            cur_y_q    <= START_YC;
            dir_q      <= '0;
            loc_q      <= '0;
            chk_q      <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            path_len_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            dir_q      <= dir_d;
            loc_q      <= loc_d;
            chk_q      <= chk_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            path_len_q <= path_len_d;
        end
    end

    assign mem.mem_loc = loc_q;
    assign mem.mem_rd  = (state_q == S_RD);
    assign mem.mem_wr  = (state_q == S_MARK);
    assign mem.mem_din = (state_q == S_MARK);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign fail        = fail_q;
    assign path_len    = path_len_q;

endmodule
